// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// Port OVF exists only when ADD_OVF_EN is defined.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C;
`ifdef ADD_OVF_EN
  logic             OVF;

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, S, C, OVF
  );
  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, S, C, OVF
  );
`else
  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, S, C
  );
  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, S, C
  );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-propagating slices, one register per slice,
// with valid/ready on both sides. Define ADD_OVF_EN to add the signed-overflow output.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic               CLK,
  input logic               nRST,
  pipelined_adder_if.slave  bus
);

  localparam int SW = WIDTH / STAGES;

  logic             w_stall;
  logic [WIDTH-1:0] w_beff;
  logic             w_cin0;

  // Subtraction is folded in once at the entry: B is inverted and the stage-0 carry forced to 1.
  assign w_beff = bus.Sub ? ~bus.B : bus.B;
  assign w_cin0 = bus.Sub ? 1'b1 : bus.Cin;

  assign w_stall      = g_stage[STAGES-1].r_v & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]         w_a;
    logic [SW-1:0]         w_b;
    logic                  w_ci;
    logic                  w_vi;
    logic [SW:0]           w_sum;
    logic [(k+1)*SW-1:0]   w_s_next;
    logic                  r_v;
    logic                  r_c;
    logic [(k+1)*SW-1:0]   r_s;

    if (k == 0) begin : g_first
      assign w_a      = bus.A[SW-1:0];
      assign w_b      = w_beff[SW-1:0];
      assign w_ci     = w_cin0;
      assign w_vi     = bus.in_valid;
      assign w_s_next = w_sum[SW-1:0];
    end else begin : g_next
      assign w_a      = g_stage[k-1].g_op.r_ua[SW-1:0];
      assign w_b      = g_stage[k-1].g_op.r_ub[SW-1:0];
      assign w_ci     = g_stage[k-1].r_c;
      assign w_vi     = g_stage[k-1].r_v;
      assign w_s_next = {w_sum[SW-1:0], g_stage[k-1].r_s};
    end

    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{SW{1'b0}}, w_ci};

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (!w_stall) begin
        r_v <= w_vi;
        if (w_vi) begin
          r_c <= w_sum[SW];
          r_s <= w_s_next;
        end
      end
    end

    // Operand bits not yet consumed travel alongside their beat; the last stage needs none.
    if (k < STAGES-1) begin : g_op
      localparam int UW = WIDTH - (k+1)*SW;
      logic [UW-1:0] w_ua_next;
      logic [UW-1:0] w_ub_next;
      logic [UW-1:0] r_ua;
      logic [UW-1:0] r_ub;

      if (k == 0) begin : g_src_in
        assign w_ua_next = bus.A[WIDTH-1:SW];
        assign w_ub_next = w_beff[WIDTH-1:SW];
      end else begin : g_src_prev
        assign w_ua_next = g_stage[k-1].g_op.r_ua[UW+SW-1:SW];
        assign w_ub_next = g_stage[k-1].g_op.r_ub[UW+SW-1:SW];
      end

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          r_ua <= '0;
          r_ub <= '0;
        end else if (!w_stall && w_vi) begin
          r_ua <= w_ua_next;
          r_ub <= w_ub_next;
        end
      end
    end

`ifdef ADD_OVF_EN
    // The operand MSBs reach the final slice inside the delayed operand slices.
    if (k == STAGES-1) begin : g_ovf
      logic r_ovf;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          r_ovf <= 1'b0;
        end else if (!w_stall && w_vi) begin
          r_ovf <= (w_a[SW-1] == w_b[SW-1]) & (w_sum[SW-1] != w_a[SW-1]);
        end
      end

      assign bus.OVF = r_ovf;
    end
`endif
  end

  assign bus.out_valid = g_stage[STAGES-1].r_v;
  assign bus.S         = g_stage[STAGES-1].r_s;
  assign bus.C         = g_stage[STAGES-1].r_c;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4); OVF checks under ADD_OVF_EN.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           t;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         su;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  vec_t tbl [8] = '{
    '{16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0},
    '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}
  };

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W), .STAGES(N)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic su);
    logic [W-1:0] be;
    logic [W:0]   r;
    exp_t         e;
    be  = su ? ~b : b;
    r   = {1'b0, a} + {1'b0, be};
    r   = r + {{W{1'b0}}, (su ? 1'b1 : ci)};
    e.s = r[W-1:0];
    e.c = r[W];
    e.o = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    e.t = 0;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic su);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = ci;
    bus.Sub      = su;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.S !== 16'h0000 || bus.C !== 1'b0) begin
      miscompares++; $display("FAIL reset_sc: got S=%h C=%b want S=0000 C=0", bus.S, bus.C);
    end
`ifdef ADD_OVF_EN
    vectors++;
    if (bus.OVF !== 1'b0) begin
      miscompares++; $display("FAIL reset_ovf: got %b want 0", bus.OVF);
    end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    exp_t e, x;
    for (int i = 0; i < 8; i++) begin
      int seen = 0;
      for (int k = 0; k < 20 && seen == 0; k++) begin
        @(negedge clk);
        bus.out_ready = 1'b1;
        if (k == 0) drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].su);
        else        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        if (bus.in_valid && bus.in_ready) begin
          e.s = tbl[i].s; e.c = tbl[i].c; e.o = tbl[i].o; e.t = cyc + 1;
          sb.push_back(e);
        end
        if (bus.out_valid && bus.out_ready) begin
          seen = 1;
          vectors++;
          if (sb.size() == 0) begin
            miscompares++; $display("FAIL dir_spurious[%0d]: result with empty scoreboard", i);
          end else begin
            x = sb.pop_front();
            if (bus.S !== x.s || bus.C !== x.c || (cyc + 1 - x.t) != N) begin
              miscompares++;
              $display("FAIL dir_result[%0d]: got S=%h C=%b lat=%0d want S=%h C=%b lat=%0d",
                       i, bus.S, bus.C, cyc + 1 - x.t, x.s, x.c, N);
            end
`ifdef ADD_OVF_EN
            vectors++;
            if (bus.OVF !== x.o) begin
              miscompares++; $display("FAIL dir_ovf[%0d]: got %b want %b", i, bus.OVF, x.o);
            end
`endif
          end
        end
      end
      vectors++;
      if (seen == 0) begin
        miscompares++; $display("FAIL dir_timeout[%0d]: got no result want one", i);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++; $display("FAIL dir_pulse[%0d]: got out_valid=%b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a [32];
    logic [W-1:0] b [32];
    logic         ci [32];
    logic         su [32];
    int           sent = 0;
    int           got = 0;
    bit           dropped = 0;
    exp_t         e, x;
    for (int i = 0; i < 32; i++) begin
      a[i]  = W'($urandom);
      b[i]  = W'($urandom);
      ci[i] = 1'($urandom_range(0, 1));
      su[i] = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < 200 && got < 32; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (sent < 32) drive(1'b1, a[sent], b[sent], ci[sent], su[sent]);
      else           drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      if (bus.in_ready !== 1'b1) dropped = 1;
      if (bus.in_valid && bus.in_ready) begin
        e = model(a[sent], b[sent], ci[sent], su[sent]);
        e.t = cyc + 1;
        sb.push_back(e);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL b2b_spurious[%0d]: result with empty scoreboard", got);
        end else begin
          x = sb.pop_front();
          if (bus.S !== x.s || bus.C !== x.c || (cyc + 1 - x.t) != N) begin
            miscompares++;
            $display("FAIL b2b_result[%0d]: got S=%h C=%b lat=%0d want S=%h C=%b lat=%0d",
                     got, bus.S, bus.C, cyc + 1 - x.t, x.s, x.c, N);
          end
        end
        got++;
      end
    end
    vectors++;
    if (got != 32) begin
      miscompares++; $display("FAIL b2b_count: got %0d results want 32", got);
    end
    vectors++;
    if (dropped) begin
      miscompares++; $display("FAIL b2b_in_ready: got a cycle with in_ready=0 want always 1");
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a [20];
    logic [W-1:0] b [20];
    logic         su [20];
    int           sent = 0;
    int           got = 0;
    logic         hold = 1'b0;
    logic [W-1:0] prev_s = '0;
    logic         prev_c = 1'b0;
    logic         want_rdy;
    exp_t         e, x;
    for (int i = 0; i < 20; i++) begin
      a[i]  = W'($urandom);
      b[i]  = W'($urandom);
      su[i] = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < 300 && got < 20; k++) begin
      @(negedge clk);
      bus.out_ready = !(k >= 8 && k < 13);
      if (sent < 20) drive(1'b1, a[sent], b[sent], 1'b1, su[sent]);
      else           drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      want_rdy = !(k >= 8 && k < 13);
      vectors++;
      if (bus.in_ready !== want_rdy) begin
        miscompares++; $display("FAIL bp_in_ready[k=%0d]: got %b want %b", k, bus.in_ready, want_rdy);
      end
      if (hold) begin
        vectors++;
        if (bus.S !== prev_s || bus.C !== prev_c || bus.out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_hold[k=%0d]: got S=%h C=%b v=%b want S=%h C=%b v=1",
                   k, bus.S, bus.C, bus.out_valid, prev_s, prev_c);
        end
      end
      hold   = !bus.out_ready;
      prev_s = bus.S;
      prev_c = bus.C;
      if (bus.in_valid && bus.in_ready) begin
        e = model(a[sent], b[sent], 1'b1, su[sent]);
        sb.push_back(e);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL bp_spurious[%0d]: result with empty scoreboard", got);
        end else begin
          x = sb.pop_front();
          if (bus.S !== x.s || bus.C !== x.c) begin
            miscompares++;
            $display("FAIL bp_result[%0d]: got S=%h C=%b want S=%h C=%b", got, bus.S, bus.C, x.s, x.c);
          end
        end
        got++;
      end
    end
    vectors++;
    if (got != 20 || sb.size() != 0) begin
      miscompares++; $display("FAIL bp_count: got %0d results, %0d left want 20, 0", got, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int   sent = 0;
    bit   full = 0;
    bit   leaked = 0;
    int   seen = 0;
    int   t_acc = 0;
    for (int k = 0; k < 20 && !full; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (sent < 3) drive(1'b1, 16'h1111 * W'(sent + 1), 16'h0202, 1'b0, 1'b0);
      else          drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid) full = 1;
    end
    vectors++;
    if (!full || sent != 3) begin
      miscompares++; $display("FAIL rst_mid_setup: got full=%0d sent=%0d want 1, 3", full, sent);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.S !== 16'h0000 || bus.C !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_clear: got v=%b S=%h C=%b want 0 0000 0", bus.out_valid, bus.S, bus.C);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid !== 1'b0) leaked = 1;
    end
    vectors++;
    if (leaked) begin
      miscompares++; $display("FAIL rst_mid_leak: got out_valid=1 after reset want 0");
    end
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (k == 0) drive(1'b1, 16'h4321, 16'h1111, 1'b0, 1'b0);
      else        drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      if (bus.in_valid && bus.in_ready) t_acc = cyc + 1;
      if (bus.out_valid && bus.out_ready) begin
        seen = 1;
        vectors++;
        if (bus.S !== 16'h5432 || bus.C !== 1'b0 || (cyc + 1 - t_acc) != N) begin
          miscompares++;
          $display("FAIL rst_mid_next: got S=%h C=%b lat=%0d want S=5432 C=0 lat=%0d",
                   bus.S, bus.C, cyc + 1 - t_acc, N);
        end
      end
    end
    vectors++;
    if (seen == 0) begin
      miscompares++; $display("FAIL rst_mid_timeout: got no result want one");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor of the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands in STAGES carry-propagating slices, one register stage per slice.
- Sustains one operation per cycle with a valid/ready handshake on both sides.
- Sits between operand-producing logic and downstream consumers where a single-cycle WIDTH-bit ripple chain would miss timing.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline slices; each slice handles WIDTH/STAGES bits; 1 <= STAGES <= WIDTH.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- nRST  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts an operand beat this cycle.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in; used only when Sub=0.
- Sub  input  1  0: add; 1: subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts a result beat this cycle.
- S  output  WIDTH  sum/difference.
- C  output  1  carry-out; for subtract, 1 = no borrow.
- OVF  output  1  signed overflow; present only with ADD_OVF_EN.

Behaviour:
- Arithmetic:
  - Sub=0: {C,S} = A + B + Cin.
  - Sub=1: {C,S} = A + ~B + 1; Cin is ignored.
  - All sums are WIDTH+1 bits, with no truncation other than C.
- Slicing:
  - Slice k (k = 0..STAGES-1) covers bits [k*W/STAGES +: W/STAGES].
  - Stage k adds slice k of the operand, using the carry registered by stage k-1; stage 0 uses Cin, or 1 when subtracting.
  - Upper operand slices are delay-registered until their stage.
  - Finished lower sum slices are delay-registered to the output so that every bit of a result appears in the same cycle.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready at edge n) to out_valid at edge n+STAGES, provided there is no stall. STAGES=1 yields a registered full-width adder.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - During stall, every stage register (data, carry, valid) holds its value.
  - S, C, OVF and out_valid remain stable while out_valid=1 and out_ready=0.
  - Without stall, valid bits shift one stage per cycle. Bubbles propagate and are not compacted.
- Throughput: one beat per cycle when out_ready is held high.
- Simultaneous events:
  - Accept and emit in the same cycle is legal.
  - in_valid while in_ready=0: the beat is not captured, and the producer must hold it.
- Reset:
  - nRST low immediately clears all stage valid bits, S, C, OVF and the internal carries to 0.
  - out_valid=0 during and after reset; in_ready=1 after reset.
  - Any reset mid-operation discards in-flight beats, and no partial result is emitted.
- Wrap-around: results are modulo 2^WIDTH with carry in C. For example, WIDTH=16, A=16'hFFFF, B=16'h0001, Cin=0 -> S=16'h0000, C=1.
- Data on S/C while out_valid=0 is don't-care, but must not be X after reset.

Optional Feature:
- Macro ADD_OVF_EN.
- Defined:
  - Port OVF exists.
  - OVF = (a_msb == b_eff_msb) & (s_msb != a_msb), where b_eff = Sub ? ~B : B.
  - OVF is computed in the final stage from MSBs carried through the pipeline, and is aligned with S and C.
  - Reset value is 0. OVF holds under stall like the other outputs.
- Undefined: the OVF port and its MSB delay registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then single add (W=16, S=4): A=16'h1234, B=16'h0FCD, Cin=1, Sub=0, out_ready=1 -> out_valid pulses 4 cycles after accept; S=16'h2202, C=0.
- Carry ripple across all slices: A=16'hFFFF, B=16'h0000, Cin=1 -> S=16'h0000, C=1. Then A=16'h0005, B=16'h0003, Sub=1 -> S=16'h0002, C=1. Then A=3, B=5, Sub=1 -> S=16'hFFFE, C=0.
- Back-to-back stream of 32 random beats with out_ready=1 -> in_ready never drops; 32 results in order, each matching the reference model, 4-cycle latency.
- Backpressure: stream in, drop out_ready for 5 cycles mid-stream -> in_ready=0 exactly while out_valid & ~out_ready; S/C held stable; no beat lost or duplicated; order preserved.
- Reset mid-operation: three beats in flight, pulse nRST low asynchronously between edges -> out_valid=0 immediately, S=0, C=0; none of the three results ever appears; the next accepted beat completes normally.
- ADD_OVF_EN: A=16'h7FFF, B=16'h0001, Sub=0 -> S=16'h8000, OVF=1. Then A=16'h8000, B=16'h0001, Sub=1 -> S=16'h7FFF, OVF=1. Then A=16'h0001, B=16'h0001 -> OVF=0.
